// File: rtl/seq_decoder.sv
`default_nettype none
// ============================================================================
// seq_decoder : FIFO-buffered 2-to-4 decoder replaying each code as a
//               one-hot pulse held for HOLD cycles.
// Revision    : 1.0
// ============================================================================
module seq_decoder #(
  parameter int unsigned HOLD  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     x,
  input  logic                     y,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     a,
  output logic                     b,
  output logic                     c,
  output logic                     d,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  localparam logic [LW-1:0] C_DEPTH   = LW'(DEPTH);
  localparam logic [7:0]    C_HOLD_M1 = 8'(HOLD - 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [1:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [0:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    oh_q, oh_d;
  logic          push;
  logic          pop;
  logic [3:0]    head_oh;

  assign in_ready = (level_q < C_DEPTH);
  assign push     = in_valid && in_ready;
  assign level    = level_q;

  // Bit order {a,b,c,d}: code 3 lights a, code 0 lights d.
  assign head_oh  = 4'b0001 << mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {x, y};
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      oh_q     <= 4'b0000;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      oh_q     <= oh_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // On hold expiry the next buffered code is loaded directly, so no gap cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oh_d    = oh_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          oh_d    = head_oh;
          cnt_d   = C_HOLD_M1;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (level_q != '0) begin
          pop   = 1'b1;
          oh_d  = head_oh;
          cnt_d = C_HOLD_M1;
        end else begin
          oh_d    = 4'b0000;
          state_d = S_IDLE;
        end
      end
      default: begin
        oh_d    = 4'b0000;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy         = (state_q == S_ACTIVE);
    {a, b, c, d} = oh_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_decoder.sv
`default_nettype none
// ============================================================================
// tb_seq_decoder : table vectors plus scoreboard-checked streams for
//                  seq_decoder (HOLD=4 and HOLD=1 instances).
// Revision       : 1.0
// ============================================================================
module tb_seq_decoder;

  localparam int unsigned HOLD0 = 4;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       x0, y0, v0, rdy0, a0, b0, c0, d0, busy0;
  logic [2:0] level0;
  logic       x1, y1, v1, rdy1, a1, b1, c1, d1, busy1;
  logic [2:0] level1;

  int checks = 0;
  int errors = 0;

  logic [1:0] sb [$];

  typedef struct {
    logic [1:0] code;
    logic [3:0] exp_oh;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  seq_decoder #(.HOLD(HOLD0), .DEPTH(DEPTH)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .x(x0), .y(y0), .in_valid(v0), .in_ready(rdy0),
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .level(level0)
  );

  seq_decoder #(.HOLD(1), .DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .in_valid(v1), .in_ready(rdy1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .level(level1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] expect_oh(input logic [1:0] code);
    case (code)
      2'b11:   return 4'b1000;
      2'b10:   return 4'b0100;
      2'b01:   return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  // Scoreboard monitor on the HOLD=4 instance: order, stability, pulse length.
  logic [3:0] prev_oh = 4'b0;
  int         run_len = 0;
  always @(negedge clk) begin
    logic [3:0] oh;
    logic [1:0] e;
    if (!rst_n) begin
      prev_oh = 4'b0;
      run_len = 0;
    end else begin
      oh = {a0, b0, c0, d0};
      if ($countones(oh) > 1) chk("multi_hot", oh, 0);
      if (busy0 !== (oh != 4'b0)) chk("busy_vs_out", busy0, (oh != 4'b0));
      if (oh != 4'b0) begin
        if (prev_oh == 4'b0 || run_len == HOLD0) begin
          if (sb.size() == 0) begin
            chk("unexpected_pulse", oh, 0);
          end else begin
            e = sb.pop_front();
            chk("order", oh, expect_oh(e));
          end
          run_len = 1;
        end else begin
          chk("stable", oh, prev_oh);
          run_len++;
        end
      end else if (prev_oh != 4'b0) begin
        chk("pulse_len", run_len, HOLD0);
      end
      prev_oh = oh;
    end
  end

  task automatic single_code(input logic [1:0] code, input logic [3:0] exp);
    {x0, y0} = code;
    v0 = 1'b1;
    chk("ready_idle", rdy0, 1);
    if (rdy0) sb.push_back(code);
    @(negedge clk);
    v0 = 1'b0;
    chk("lat_level", level0, 1);
    chk("lat_out", {a0, b0, c0, d0}, 0);
    for (int k = 0; k < HOLD0; k++) begin
      @(negedge clk);
      chk("hold_out", {a0, b0, c0, d0}, exp);
      chk("hold_busy", busy0, 1);
    end
    @(negedge clk);
    chk("end_out", {a0, b0, c0, d0}, 0);
    chk("end_busy", busy0, 0);
    chk("end_level", level0, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy0 || level0 != 3'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (busy0 || level0 != 3'd0), 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] stream [4];
    logic [1:0] bp_codes [6];
    int         acc_edge [6];
    int         idx;
    int         busy_cnt;
    int         guard;
    logic [1:0] h1_codes [4];
    logic [3:0] h1_exp [6];

    vecs[0].code = 2'b10; vecs[0].exp_oh = 4'b0100;
    vecs[1].code = 2'b11; vecs[1].exp_oh = 4'b1000;
    vecs[2].code = 2'b01; vecs[2].exp_oh = 4'b0010;
    vecs[3].code = 2'b00; vecs[3].exp_oh = 4'b0001;

    rst_n = 1'b0;
    {x0, y0, v0, x1, y1, v1} = '0;
    #3;
    chk("rst_out", {a0, b0, c0, d0}, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_level", level0, 0);
    chk("rst_ready", rdy0, 1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) single_code(vecs[i].code, vecs[i].exp_oh);

    // Ordered stream: four contiguous pulses, 16 busy cycles in total.
    stream = '{2'b00, 2'b01, 2'b10, 2'b11};
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      {x0, y0} = stream[i];
      v0 = 1'b1;
      if (rdy0) sb.push_back(stream[i]);
      @(negedge clk);
      if (busy0) busy_cnt++;
    end
    v0 = 1'b0;
    guard = 0;
    while (busy0 && guard < 40) begin
      @(negedge clk);
      if (busy0) busy_cnt++;
      guard++;
    end
    chk("stream_contig", busy_cnt, 16);
    wait_idle(40);

    // Backpressure: six codes with in_valid held.
    bp_codes = '{2'b11, 2'b01, 2'b01, 2'b10, 2'b00, 2'b11};
    idx = 0;
    for (int cyc = 1; cyc <= 12 && idx < 6; cyc++) begin
      {x0, y0} = bp_codes[idx];
      v0 = 1'b1;
      if (rdy0) begin
        sb.push_back(bp_codes[idx]);
        acc_edge[idx] = cyc;
        idx++;
      end
      @(negedge clk);
      if (cyc == 5) begin
        chk("full_level", level0, 4);
        chk("full_ready", rdy0, 0);
      end
      if (cyc == 6) chk("after_pop_level", level0, 3);
    end
    v0 = 1'b0;
    chk("bp_accepted", idx, 6);
    chk("bp_edge5", acc_edge[4], 5);
    chk("bp_edge6", acc_edge[5], 7);
    wait_idle(60);

    // Reset mid-pulse with codes still buffered.
    for (int i = 0; i < 3; i++) begin
      {x0, y0} = stream[i];
      v0 = 1'b1;
      if (rdy0) sb.push_back(stream[i]);
      @(negedge clk);
    end
    v0 = 1'b0;
    chk("pre_rst_busy", busy0, 1);
    chk("pre_rst_level", level0, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", {a0, b0, c0, d0}, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_level", level0, 0);
    chk("arst_ready", rdy0, 1);
    sb.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {busy0, a0, b0, c0, d0}, 0);
    end
    single_code(2'b01, 4'b0010);

    // HOLD=1 instance: one code per cycle, in_ready stays high.
    h1_codes = '{2'b11, 2'b00, 2'b11, 2'b00};
    h1_exp   = '{4'b0000, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b0000};
    for (int s = 0; s < 6; s++) begin
      if (s < 4) begin
        {x1, y1} = h1_codes[s];
        v1 = 1'b1;
      end else begin
        v1 = 1'b0;
      end
      chk("h1_ready", rdy1, 1);
      @(negedge clk);
      chk("h1_out", {a1, b1, c1, d1}, h1_exp[s]);
    end
    chk("h1_busy_end", busy1, 0);
    chk("h1_level_end", level1, 0);

    chk("sb_final", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
